// File: rtl/mult_product_accumulator.sv
// -----------------------------------------------------------------------------
// mult_product_accumulator
//
// Sequential stage behind the 4-bit array multiplier. It sums a frame of
// consecutive 8-bit products into a wide saturating accumulator and emits one
// result per frame.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
// both high. The producer holds data stable while valid is high and ready is
// low. Ready never waits for valid. Valid never drops without a transfer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   p_in       unsigned product from the multiplier
//   p_valid    p_in valid this cycle
//   p_last     p_in is the final term of the frame (qualified by p_valid)
//   p_ready    stage accepts a product this cycle
//   acc_out    frame sum (saturated to all-ones on overflow)
//   acc_terms  number of products summed into acc_out
//   acc_ovf    frame sum exceeded ACC_W bits
//   acc_trunc  frame closed at MAX_TERMS without p_last
//   acc_valid  result outputs valid
//   acc_ready  downstream accepts the result
//   dbg_state  debug view of the FSM (0 = COLLECT, 1 = HOLD)
// -----------------------------------------------------------------------------
module mult_product_accumulator #(
   parameter int ACC_W     = 12,   // must be >= 8
   parameter int MAX_TERMS = 16,
   parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       p_in,
   input  logic             p_valid,
   input  logic             p_last,
   output logic             p_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] acc_terms,
   output logic             acc_ovf,
   output logic             acc_trunc,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic             dbg_state
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] out_q, out_d;
   logic [CNT_W-1:0] terms_q, terms_d;
   logic             out_ovf_q, out_ovf_d;
   logic             trunc_q, trunc_d;

   logic             accept;
   logic             handoff;
   logic             close;
   logic [ACC_W:0]   nxt;
   logic             sat;
   logic [ACC_W-1:0] sum_new;
   logic [CNT_W-1:0] cnt_inc;

   // Combinational pass-through of acc_ready lets a new frame close in the
   // same cycle the previous result is handed off, so there is no bubble.
   assign p_ready = (state_q == COLLECT) || acc_ready;
   assign accept  = p_valid && p_ready;
   assign handoff = (state_q == HOLD) && acc_ready;

   // One extra bit catches the carry. Once a frame has overflowed it stays
   // pinned at all-ones until the frame closes.
   assign nxt     = {1'b0, sum_q} + {{(ACC_W - 7){1'b0}}, p_in};
   assign sat     = nxt[ACC_W] || ovf_q;
   assign sum_new = sat ? {ACC_W{1'b1}} : nxt[ACC_W-1:0];
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign close   = accept && (p_last || (cnt_inc == MAX_CNT));

   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      out_d     = out_q;
      terms_d   = terms_q;
      out_ovf_d = out_ovf_q;
      trunc_d   = trunc_q;

      if (close) begin
         out_d     = sum_new;
         terms_d   = cnt_inc;
         out_ovf_d = sat;
         trunc_d   = !p_last;
         state_d   = HOLD;
         sum_d     = '0;
         cnt_d     = '0;
         ovf_d     = 1'b0;
      end else begin
         if (accept) begin
            sum_d = sum_new;
            cnt_d = cnt_inc;
            ovf_d = sat;
         end
         if (handoff) begin
            state_d = COLLECT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= COLLECT;
         sum_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         out_q     <= '0;
         terms_q   <= '0;
         out_ovf_q <= 1'b0;
         trunc_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         out_q     <= out_d;
         terms_q   <= terms_d;
         out_ovf_q <= out_ovf_d;
         trunc_q   <= trunc_d;
      end
   end

   assign acc_out   = out_q;
   assign acc_terms = terms_q;
   assign acc_ovf   = out_ovf_q;
   assign acc_trunc = trunc_q;
   assign acc_valid = (state_q == HOLD);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mult_product_accumulator
//
// Three instances share clock and reset:
//   d0: default parameters (ACC_W=12, MAX_TERMS=16)
//   d1: ACC_W=8 for saturation and back-to-back frames
//   d2: MAX_TERMS=4 for forced frame close
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// 2 time units after the edge, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mult_product_accumulator;

   logic        clk;
   logic        rst_n;
   logic [7:0]  p_in      [3];
   logic        p_valid   [3];
   logic        p_last    [3];
   logic        acc_ready [3];
   logic        p_ready   [3];
   logic [11:0] acc_out   [3];
   logic [4:0]  acc_terms [3];
   logic        acc_ovf   [3];
   logic        acc_trunc [3];
   logic        acc_valid [3];
   logic        dbg_state [3];

   logic [7:0]  out1;
   logic [4:0]  terms0, terms1;
   logic [11:0] out0, out2;
   logic [2:0]  terms2;

   int n_checks = 0;
   int n_errors = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   mult_product_accumulator u_d0 (
      .clk(clk), .rst_n(rst_n), .p_in(p_in[0]), .p_valid(p_valid[0]),
      .p_last(p_last[0]), .p_ready(p_ready[0]), .acc_out(out0),
      .acc_terms(terms0), .acc_ovf(acc_ovf[0]), .acc_trunc(acc_trunc[0]),
      .acc_valid(acc_valid[0]), .acc_ready(acc_ready[0]),
      .dbg_state(dbg_state[0])
   );

   mult_product_accumulator #(.ACC_W(8)) u_d1 (
      .clk(clk), .rst_n(rst_n), .p_in(p_in[1]), .p_valid(p_valid[1]),
      .p_last(p_last[1]), .p_ready(p_ready[1]), .acc_out(out1),
      .acc_terms(terms1), .acc_ovf(acc_ovf[1]), .acc_trunc(acc_trunc[1]),
      .acc_valid(acc_valid[1]), .acc_ready(acc_ready[1]),
      .dbg_state(dbg_state[1])
   );

   mult_product_accumulator #(.MAX_TERMS(4)) u_d2 (
      .clk(clk), .rst_n(rst_n), .p_in(p_in[2]), .p_valid(p_valid[2]),
      .p_last(p_last[2]), .p_ready(p_ready[2]), .acc_out(out2),
      .acc_terms(terms2), .acc_ovf(acc_ovf[2]), .acc_trunc(acc_trunc[2]),
      .acc_valid(acc_valid[2]), .acc_ready(acc_ready[2]),
      .dbg_state(dbg_state[2])
   );

   assign acc_out[0]   = out0;
   assign acc_out[1]   = {4'd0, out1};
   assign acc_out[2]   = out2;
   assign acc_terms[0] = terms0;
   assign acc_terms[1] = terms1;
   assign acc_terms[2] = {2'd0, terms2};

   // driver tasks
   task automatic drv(input int d, input logic v, input logic [7:0] p,
                      input logic l);
      p_valid[d] = v;
      p_in[d]    = p;
      p_last[d]  = l;
   endtask

   // advance one clock edge and land at the drive point
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // settle after driving, before checking
   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input string tag, input int d,
                             input logic [11:0] o, input logic [4:0] t,
                             input logic ovf, input logic tr);
      chk({tag, ".valid"}, 32'(acc_valid[d]), 32'd1);
      chk({tag, ".out"},   32'(acc_out[d]),   32'(o));
      chk({tag, ".terms"}, 32'(acc_terms[d]), 32'(t));
      chk({tag, ".ovf"},   32'(acc_ovf[d]),   32'(ovf));
      chk({tag, ".trunc"}, 32'(acc_trunc[d]), 32'(tr));
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drv(i, 1'b0, 8'd0, 1'b0);
         acc_ready[i] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle();

      // reset state
      for (int i = 0; i < 3; i++) begin
         chk("rst.valid", 32'(acc_valid[i]), 32'd0);
         chk("rst.out",   32'(acc_out[i]),   32'd0);
         chk("rst.terms", 32'(acc_terms[i]), 32'd0);
         chk("rst.ovf",   32'(acc_ovf[i]),   32'd0);
         chk("rst.trunc", 32'(acc_trunc[i]), 32'd0);
         chk("rst.ready", 32'(p_ready[i]),   32'd1);
         chk("rst.state", 32'(dbg_state[i]), 32'd0);
      end

      // frame 6, 10, 225(last) -> 241
      step(); drv(0, 1'b1, 8'd6, 1'b0);
      step(); drv(0, 1'b1, 8'd10, 1'b0);
      settle(); chk("f1.mid_valid", 32'(acc_valid[0]), 32'd0);
      step(); drv(0, 1'b1, 8'd225, 1'b1);
      step(); drv(0, 1'b0, 8'd0, 1'b0);
      settle(); chk_result("f1", 0, 12'd241, 5'd3, 1'b0, 1'b0);
      chk("f1.state", 32'(dbg_state[0]), 32'd1);
      step(); settle();
      chk("f1.pulse_end", 32'(acc_valid[0]), 32'd0);

      // ACC_W=8 saturation: 200, 100, 50(last) -> 255 with ovf
      drv(1, 1'b1, 8'd200, 1'b0);
      step(); drv(1, 1'b1, 8'd100, 1'b0);
      step(); drv(1, 1'b1, 8'd50, 1'b1);
      step(); drv(1, 1'b1, 8'd5, 1'b1);
      settle(); chk_result("sat", 1, 12'd255, 5'd3, 1'b1, 1'b0);
      step(); drv(1, 1'b0, 8'd0, 1'b0);
      settle(); chk_result("sat_clr", 1, 12'd5, 5'd1, 1'b0, 1'b0);
      step(); settle();
      chk("sat_clr.end", 32'(acc_valid[1]), 32'd0);

      // MAX_TERMS=4: five ones, last on the fifth
      drv(2, 1'b1, 8'd1, 1'b0);
      step(); step(); step();
      settle(); chk("trunc.mid_valid", 32'(acc_valid[2]), 32'd0);
      step(); drv(2, 1'b1, 8'd1, 1'b1);
      settle(); chk_result("trunc1", 2, 12'd4, 5'd4, 1'b0, 1'b1);
      chk("trunc1.ready", 32'(p_ready[2]), 32'd1);
      step(); drv(2, 1'b0, 8'd0, 1'b0);
      settle(); chk_result("trunc2", 2, 12'd1, 5'd1, 1'b0, 1'b0);
      step();

      // backpressure: result 3 pending, acc_ready low for 3 cycles
      acc_ready[0] = 1'b0;
      drv(0, 1'b1, 8'd3, 1'b1);
      step(); drv(0, 1'b1, 8'd8, 1'b1);
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("bp.p_ready", 32'(p_ready[0]), 32'd0);
         chk_result("bp.hold", 0, 12'd3, 5'd1, 1'b0, 1'b0);
         step();
      end
      acc_ready[0] = 1'b1;
      settle(); chk("bp.release_ready", 32'(p_ready[0]), 32'd1);
      step(); drv(0, 1'b0, 8'd0, 1'b0);
      settle(); chk_result("bp.next", 0, 12'd8, 5'd1, 1'b0, 1'b0);
      step(); settle();
      chk("bp.end", 32'(acc_valid[0]), 32'd0);

      // back-to-back single-term frames 7, 9, 11
      drv(1, 1'b1, 8'd7, 1'b1);
      step(); drv(1, 1'b1, 8'd9, 1'b1);
      settle(); chk_result("b2b0", 1, 12'd7, 5'd1, 1'b0, 1'b0);
      step(); drv(1, 1'b1, 8'd11, 1'b1);
      settle(); chk_result("b2b1", 1, 12'd9, 5'd1, 1'b0, 1'b0);
      step(); drv(1, 1'b0, 8'd0, 1'b0);
      settle(); chk_result("b2b2", 1, 12'd11, 5'd1, 1'b0, 1'b0);
      step(); settle();
      chk("b2b.end", 32'(acc_valid[1]), 32'd0);

      // reset mid-frame after 20, 30 accepted; d0 still shows result 8
      drv(0, 1'b1, 8'd20, 1'b0);
      step(); drv(0, 1'b1, 8'd30, 1'b0);
      step(); drv(0, 1'b0, 8'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.out",   32'(acc_out[0]),   32'd0);
      chk("arst.terms", 32'(acc_terms[0]), 32'd0);
      chk("arst.valid", 32'(acc_valid[0]), 32'd0);
      chk("arst.ready", 32'(p_ready[0]),   32'd1);
      step();
      rst_n = 1'b1;
      drv(0, 1'b1, 8'd4, 1'b1);
      step(); drv(0, 1'b0, 8'd0, 1'b0);
      settle(); chk_result("arst.after", 0, 12'd4, 5'd1, 1'b0, 1'b0);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
